// File: rtl/trivium_stream_driver_pkg.sv
// Shared constants for the Trivium stream driver: default core widths and FSM encodings.
package trivium_stream_driver_pkg;
  localparam int KEY_W_DEF = 80;
  localparam int IV_W_DEF  = 80;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_KEY    = 3'd1;
  localparam logic [2:0] S_IV     = 3'd2;
  localparam logic [2:0] S_GATHER = 3'd3;
  localparam logic [2:0] S_XOR    = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;
endpackage

// File: rtl/trivium_stream_driver_if.sv
// Word-stream ports of the driver: input words in, XORed words out, both valid/ready.
interface trivium_stream_driver_if #(parameter int WORD_W = 32);
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  // master is the host side (source + sink), slave is the driver
  modport master (output in_data, in_valid, out_ready,
                  input  in_ready, out_data, out_valid);
  modport slave  (input  in_data, in_valid, out_ready,
                  output in_ready, out_data, out_valid);
endinterface

// File: rtl/trivium_stream_driver_ks_packer.sv
// Packs qualified serial keystream bits into a word, first bit ending up in the MSB.
module trivium_stream_driver_ks_packer #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              vld,
  input  logic              ks,
  output logic [WORD_W-1:0] word,
  output logic              full
);
  localparam int CW = $clog2(WORD_W);

  logic [CW-1:0] bit_cnt;
  logic          take;

  assign take = en & vld;
  // full marks the edge on which the last bit of a word shifts in
  assign full = take & (bit_cnt == CW'(WORD_W-1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      bit_cnt <= '0;
      word    <= '0;
    end else if (take) begin
      word    <= {word[WORD_W-2:0], ks};
      bit_cnt <= full ? '0 : bit_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/trivium_stream_driver.sv
// Host-side initiator for a Trivium core: loads key/IV, gathers keystream words, XORs data words.
module trivium_stream_driver
  import trivium_stream_driver_pkg::*;
#(
  parameter int KEY_W  = KEY_W_DEF,
  parameter int IV_W   = IV_W_DEF,
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [KEY_W-1:0]         key,
  input  logic [IV_W-1:0]          iv,
  input  logic                     enc_dec,
  input  logic [CNT_W-1:0]         num_words,
  output logic                     busy,
  output logic                     done,
  trivium_stream_driver_if.slave   stream,
  output logic [KEY_W-1:0]         core_kin,
  output logic [IV_W-1:0]          core_din,
  output logic                     core_krdy,
  output logic                     core_drdy,
  output logic                     core_encdec,
  output logic                     core_en,
  input  logic                     core_ks,
  input  logic                     core_kvld,
  input  logic                     core_dvld,
  input  logic                     core_bsy
);
  logic [2:0]        state;
  logic [CNT_W-1:0]  words_left;
  logic [WORD_W-1:0] ks_word;
  logic              ks_full;
  logic              pack_en;
  logic              pack_clr;
  logic              in_fire;
  logic              out_fire;

  // keystream bits only count while the core runs and we are collecting
  assign pack_en   = core_en & (state == S_GATHER);
  assign pack_clr  = (state == S_IDLE) & start;
  assign core_krdy = (state == S_KEY);
  assign core_drdy = (state == S_IV);

  assign stream.in_ready = (state == S_XOR) & (~stream.out_valid | stream.out_ready);
  assign in_fire         = stream.in_valid & stream.in_ready;
  assign out_fire        = stream.out_valid & stream.out_ready;

  trivium_stream_driver_ks_packer #(.WORD_W(WORD_W)) u_packer (
    .clk  (clk),
    .rst  (rst),
    .clr  (pack_clr),
    .en   (pack_en),
    .vld  (core_dvld),
    .ks   (core_ks),
    .word (ks_word),
    .full (ks_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      core_en          <= 1'b0;
      core_kin         <= '0;
      core_din         <= '0;
      core_encdec      <= 1'b0;
      words_left       <= '0;
      stream.out_data  <= '0;
      stream.out_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      if (out_fire) stream.out_valid <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          if (num_words == '0) begin
            done <= 1'b1;
          end else begin
            core_kin    <= key;
            core_din    <= iv;
            core_encdec <= enc_dec;
            words_left  <= num_words;
            busy        <= 1'b1;
            core_en     <= 1'b1;
            state       <= S_KEY;
          end
        end
        S_KEY:    if (core_kvld) state <= S_IV;
        S_IV:     if (core_bsy)  state <= S_GATHER;
        // stall the core on the same edge the word completes so no bit is lost
        S_GATHER: if (ks_full) begin
          core_en <= 1'b0;
          state   <= S_XOR;
        end
        S_XOR: if (in_fire) begin
          stream.out_data  <= stream.in_data ^ ks_word;
          stream.out_valid <= 1'b1;
          words_left       <= words_left - CNT_W'(1);
          if (words_left == CNT_W'(1)) begin
            state <= S_DRAIN;
          end else begin
            core_en <= 1'b1;
            state   <= S_GATHER;
          end
        end
        S_DRAIN: if (out_fire) begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_trivium_stream_driver.sv
// Directed bench: behavioural core with a fixed keystream table, word source/sink, hand-computed results.
`timescale 1ns/1ps
module tb_trivium_stream_driver;
  localparam int WORD_W = 32;
  localparam int KEY_W  = 80;
  localparam int IV_W   = 80;
  localparam int CNT_W  = 16;

  localparam logic [79:0] KEY_A = 80'hFF000102030405060708;
  localparam logic [31:0] KS [8] = '{32'h01234567, 32'h89ABCDEF, 32'hF0E1D2C3, 32'h5A5AA5A5,
                                     32'h13579BDF, 32'h2468ACE0, 32'h0F0F0F0F, 32'hC3C3C3C3};
  localparam logic [31:0] IN_A [4]  = '{32'hFFFFFFFF, 32'h00000000, 32'h12345678, 32'hA5A55A5A};
  localparam logic [31:0] EXP_A [4] = '{32'hFEDCBA98, 32'h89ABCDEF, 32'hE2D584BB, 32'hFFFFFFFF};

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, enc_dec = 1'b0;
  logic [KEY_W-1:0] key = '0;
  logic [IV_W-1:0]  iv  = '0;
  logic [CNT_W-1:0] num_words = '0;
  logic busy, done;
  logic [KEY_W-1:0] core_kin;
  logic [IV_W-1:0]  core_din;
  logic core_krdy, core_drdy, core_encdec, core_en;
  logic core_ks, core_kvld, core_dvld, core_bsy;

  trivium_stream_driver_if #(.WORD_W(WORD_W)) sif ();

  always #5 clk = ~clk;

  trivium_stream_driver #(.KEY_W(KEY_W), .IV_W(IV_W), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .iv(iv), .enc_dec(enc_dec),
    .num_words(num_words), .busy(busy), .done(done), .stream(sif),
    .core_kin(core_kin), .core_din(core_din), .core_krdy(core_krdy), .core_drdy(core_drdy),
    .core_encdec(core_encdec), .core_en(core_en), .core_ks(core_ks), .core_kvld(core_kvld),
    .core_dvld(core_dvld), .core_bsy(core_bsy)
  );

  // core model: kvld a few cycles after krdy, bsy after drdy, short warm-up, then
  // keystream bits from KS with a gap every 5th cycle; junk bits while EN is low
  int phase = 0, dly = 0, ptr = 0, gap = 0;
  logic [31:0] ks_cur;
  logic        ks_bit;
  assign ks_cur    = KS[3'(ptr >> 5)];
  assign ks_bit    = ks_cur[5'(31 - (ptr & 31))];
  assign core_dvld = (phase == 5) && (!core_en || (gap % 5 != 3));
  assign core_ks   = core_en ? ks_bit : ~ks_bit;

  always @(posedge clk) begin
    gap       <= gap + 1;
    core_kvld <= 1'b0;
    if (rst) begin
      phase <= 0; ptr <= 0; core_bsy <= 1'b0;
    end else if (core_krdy && (phase == 0 || phase >= 4)) begin
      phase <= 1; dly <= 3; ptr <= 0; core_bsy <= 1'b0;
    end else begin
      case (phase)
        1: if (dly == 0) begin core_kvld <= 1'b1; phase <= 2; end else dly <= dly - 1;
        2: if (core_drdy) begin phase <= 3; dly <= 2; end
        3: if (dly == 0) begin core_bsy <= 1'b1; phase <= 4; dly <= 5; end else dly <= dly - 1;
        4: if (dly == 0) begin core_bsy <= 1'b0; phase <= 5; end else dly <= dly - 1;
        5: if (core_dvld && core_en) ptr <= ptr + 1;
        default: ;
      endcase
    end
  end

  int done_cnt = 0, krdy_bad = 0, drdy_bad = 0, krdy_after = 0, drdy_after = 0;
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (phase == 1 && !core_krdy) krdy_bad <= krdy_bad + 1;
    if (phase == 3 && !core_drdy) drdy_bad <= drdy_bad + 1;
    if (phase == 2 && core_krdy) krdy_after <= krdy_after + 1;
    if (phase == 4 && core_drdy) drdy_after <= drdy_after + 1;
  end

  int nvec = 0, nerr = 0;
  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] src [8];
  logic [31:0] cap [8];
  bit abort = 1'b0;

  task automatic go(input logic [79:0] k, input logic [79:0] v, input logic ed, input int n);
    @(negedge clk);
    key = k; iv = v; enc_dec = ed; num_words = CNT_W'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic source(input int n);
    int cyc = 0;
    for (int i = 0; i < n && !abort; i++) begin
      @(negedge clk);
      sif.in_valid = 1'b1; sif.in_data = src[i];
      #1;
      while (!sif.in_ready && !abort && cyc < 4000) begin @(negedge clk); #1; cyc++; end
      if (abort) break;
      if (cyc >= 4000) begin chk("src_timeout", 80'(cyc), 0); break; end
      @(posedge clk);
    end
    @(negedge clk);
    sif.in_valid = 1'b0;
  endtask

  task automatic sink(input int n, input int stall_at);
    int got = 0, cyc = 0, hold_p;
    logic [31:0] hold_d;
    while (got < n && !abort && cyc < 4000) begin
      @(negedge clk); cyc++;
      if (sif.out_valid && got == stall_at) begin
        sif.out_ready = 1'b0; hold_d = sif.out_data;
        repeat (60) @(negedge clk);
        hold_p = ptr;
        repeat (40) @(negedge clk);
        chk("stall_core_en", 80'(core_en), 0);
        chk("stall_no_bits", 80'(ptr), 80'(hold_p));
        chk("stall_out_data", 80'(sif.out_data), 80'(hold_d));
        chk("stall_out_valid", 80'(sif.out_valid), 1);
        stall_at = -1;
      end
      sif.out_ready = 1'b1;
      if (sif.out_valid) begin cap[got] = sif.out_data; got++; end
    end
    if (got < n && !abort) chk("snk_timeout", 80'(got), 80'(n));
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy && c < 2000) begin @(negedge clk); c++; end
    if (busy) chk("busy_timeout", 80'(busy), 0);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, k0, r0, kb0, db0;
    sif.in_valid = 1'b0; sif.in_data = '0; sif.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 80'(busy), 0);
    chk("rst_done", 80'(done), 0);
    chk("rst_in_ready", 80'(sif.in_ready), 0);
    chk("rst_out_valid", 80'(sif.out_valid), 0);
    chk("rst_core_ctl", {77'd0, core_krdy, core_drdy, core_en}, 0);
    chk("rst_out_data", 80'(sif.out_data), 0);
    rst = 1'b0;

    // four words with known key and data
    for (int i = 0; i < 4; i++) src[i] = IN_A[i];
    d0 = done_cnt; k0 = krdy_after; r0 = drdy_after;
    go(KEY_A, 80'h0, 1'b0, 4);
    chk("busy_after_start", 80'(busy), 1);
    chk("core_kin", core_kin, KEY_A);
    fork source(4); sink(4, -1); join
    wait_idle();
    for (int i = 0; i < 4; i++) chk($sformatf("enc_word%0d", i), 80'(cap[i]), 80'(EXP_A[i]));
    chk("done_once", 80'(done_cnt - d0), 1);
    chk("busy_low", 80'(busy), 0);
    chk("krdy_held", 80'(krdy_bad), 0);
    chk("krdy_drop", 80'(krdy_after - k0), 1);
    chk("drdy_held", 80'(drdy_bad), 0);
    chk("drdy_drop", 80'(drdy_after - r0), 1);
    chk("core_din", core_din, 80'h0);

    // encrypt zeros, then decrypt the result with a long sink stall on word 1
    for (int i = 0; i < 4; i++) src[i] = 32'h0;
    go(KEY_A, 80'h0, 1'b0, 4);
    fork source(4); sink(4, -1); join
    wait_idle();
    for (int i = 0; i < 4; i++) chk($sformatf("ks_word%0d", i), 80'(cap[i]), 80'(KS[i]));
    for (int i = 0; i < 4; i++) src[i] = cap[i];
    d0 = done_cnt;
    go(KEY_A, 80'h0, 1'b1, 4);
    chk("core_encdec", 80'(core_encdec), 1);
    fork source(4); sink(4, 1); join
    wait_idle();
    for (int i = 0; i < 4; i++) chk($sformatf("dec_word%0d", i), 80'(cap[i]), 0);
    chk("dec_done_once", 80'(done_cnt - d0), 1);

    // zero-length request: done next cycle, no core activity
    kb0 = krdy_after; db0 = drdy_after; d0 = done_cnt;
    go(KEY_A, 80'h0, 1'b0, 0);
    chk("zero_done", 80'(done), 1);
    chk("zero_busy", 80'(busy), 0);
    chk("zero_core_ctl", {77'd0, core_krdy, core_drdy, core_en}, 0);
    @(negedge clk);
    chk("zero_done_pulse", 80'(done), 0);
    chk("zero_no_key", 80'(krdy_after - kb0), 0);

    // start pulsed mid-run with a different key and count is ignored
    for (int i = 0; i < 4; i++) src[i] = IN_A[i];
    d0 = done_cnt;
    go(KEY_A, 80'h0, 1'b0, 4);
    fork
      source(4);
      sink(4, -1);
      begin
        repeat (30) @(negedge clk);
        key = 80'h123; num_words = 16'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_key", core_kin, KEY_A);
      end
    join
    wait_idle();
    for (int i = 0; i < 4; i++) chk($sformatf("busy_start_word%0d", i), 80'(cap[i]), 80'(EXP_A[i]));
    chk("busy_start_done", 80'(done_cnt - d0), 1);

    // reset while gathering word 2, then a fresh one-word run
    d0 = done_cnt;
    go(KEY_A, 80'h0, 1'b0, 4);
    fork
      source(4);
      sink(4, -1);
      begin
        int c = 0;
        while (!(ptr >= 72 && core_en) && c < 2000) begin @(negedge clk); c++; end
        if (c >= 2000) chk("rst_wait_timeout", 80'(c), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy_done", {78'd0, busy, done}, 0);
        chk("abort_stream", {78'd0, sif.in_ready, sif.out_valid}, 0);
        chk("abort_core_ctl", {77'd0, core_krdy, core_drdy, core_en}, 0);
        chk("abort_out_data", 80'(sif.out_data), 0);
        chk("abort_core_kin", core_kin, 0);
        abort = 1'b1;
        rst = 1'b0;
      end
    join
    abort = 1'b0;
    chk("abort_word0", 80'(cap[0]), 80'(EXP_A[0]));
    chk("abort_no_done", 80'(done_cnt - d0), 0);
    src[0] = 32'hFFFFFFFF;
    go(KEY_A, 80'h0, 1'b0, 1);
    fork source(1); sink(1, -1); join
    wait_idle();
    chk("fresh_word0", 80'(cap[0]), 80'(32'hFEDCBA98));
    chk("fresh_done", 80'(done_cnt - d0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
